processor: RTL and testbench

- Single-cycle 32-bit load/store processor with on-chip instruction and data memories, register file and ALU.
- The program and data are streamed in through a load port while start_signal is low.
- When start_signal is high, the core executes one instruction per clock from PC=0 until a HALT instruction, then raises end_signal.
- It is the top of the CPU design; testbenches drive it directly and observe it through five debug outputs.

---
 rtl/processor.sv | 150 +++++++++++++++
 tb/tb_processor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// Single-cycle 32-bit load/store core with on-chip instruction and data
// memories. Program and data are streamed in while start_signal is low;
// execution runs from PC 0 until HALT, after which end_signal stays high.
//
// state     | meaning
// S_ACTIVE  | loading (start_signal=0) or executing (start_signal=1)
// S_HALTED  | HALT retired; core frozen until reset
module processor #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_signal,
  input  logic [31:0] new_instruction,
  input  logic        add_into,
  output logic        end_signal,
  output logic [31:0] debug1,
  output logic [31:0] debug2,
  output logic [31:0] debug3,
  output logic [31:0] debug4,
  output logic [31:0] debug5
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [0:0] {S_ACTIVE = 1'b0, S_HALTED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IAW-1:0]  pc_q, iptr_q;
  logic [DAW-1:0]  dptr_q;
  logic [31:0]     retired_q;
  logic [31:0]     regs_q [32];
  logic [31:0]     imem_q [IMEM_DEPTH];
  logic [31:0]     dmem_q [DMEM_DEPTH];

  logic [31:0]     instr;
  logic [5:0]      op, fn;
  logic [4:0]      rs, rt, rd, sh;
  logic [15:0]     imm;
  logic [31:0]     imm_sext, rs_val, rt_val, ea;
  logic [DAW-1:0]  daddr;
  logic [IAW-1:0]  pc_inc, pc_d;
  logic            rf_we, dm_we, halt_req, run;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            unused_ea;

  assign instr    = imem_q[pc_q];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign sh       = instr[10:6];
  assign fn       = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs_q[rt];
  assign ea       = rs_val + imm_sext;
  assign daddr    = ea[DAW-1:0];
  assign pc_inc   = pc_q + IAW'(1);
  assign run      = (state_q == S_ACTIVE) && start_signal;
  assign unused_ea = ^ea[31:DAW];

  // Decode and execute the instruction at the current PC.
  always_comb begin
    pc_d     = pc_inc;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'd0;
    dm_we    = 1'b0;
    halt_req = 1'b0;
    unique case (op)
      6'b000000: begin
        rf_waddr = rd;
        rf_we    = 1'b1;
        case (fn)
          6'b000000: rf_wdata = rs_val + rt_val;
          6'b000001: rf_wdata = rs_val - rt_val;
          6'b000010: rf_wdata = rs_val & rt_val;
          6'b000011: rf_wdata = rs_val | rt_val;
          6'b000100: rf_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'b000101: rf_wdata = rt_val << sh;
          6'b000110: rf_wdata = rt_val >> sh;
          default:   rf_we    = 1'b0;
        endcase
      end
      6'b000001: begin rf_we = 1'b1; rf_wdata = rs_val + imm_sext;     end
      6'b000011: begin rf_we = 1'b1; rf_wdata = rs_val | {16'd0, imm}; end
      6'b000111: begin rf_we = 1'b1; rf_wdata = rs_val << imm[4:0];    end
      6'b001000: begin rf_we = 1'b1; rf_wdata = dmem_q[daddr];         end
      6'b001001: dm_we = 1'b1;
      6'b001010: if (rs_val == rt_val) pc_d = pc_inc + imm[IAW-1:0];
      6'b001011: if (rs_val != rt_val) pc_d = pc_inc + imm[IAW-1:0];
      6'b100001: pc_d = instr[IAW-1:0];
      6'b111111: begin pc_d = pc_q; halt_req = 1'b1; end
      default:   ;
    endcase
  end

  // Halt once a HALT instruction retires.
  always_comb begin
    state_d = state_q;
    if (run && halt_req) state_d = S_HALTED;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_ACTIVE;
    else        state_q <= state_d;
  end

  // Load-phase memory fill and execute-phase architectural updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      iptr_q    <= '0;
      dptr_q    <= '0;
      retired_q <= '0;
      for (int i = 0; i < 32; i++)         regs_q[i] <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else if (state_q == S_ACTIVE) begin
      if (!start_signal) begin
        if (add_into) begin
          dmem_q[dptr_q] <= new_instruction;
          dptr_q         <= dptr_q + DAW'(1);
        end else begin
          imem_q[iptr_q] <= new_instruction;
          iptr_q         <= iptr_q + IAW'(1);
        end
      end else begin
        pc_q      <= pc_d;
        retired_q <= retired_q + 32'd1;
        if (rf_we && (rf_waddr != 5'd0)) regs_q[rf_waddr] <= rf_wdata;
        if (dm_we) dmem_q[daddr] <= rt_val;
      end
    end
  end

  assign end_signal = (state_q == S_HALTED);
  assign debug1     = retired_q;
  assign debug2     = {{(32-IAW){1'b0}}, pc_q};
  assign debug3     = dmem_q[0];
  assign debug4     = regs_q[12];
  assign debug5     = instr;

endmodule

// File: tb/tb_processor.sv
// Directed bench for the processor: hand-assembled programs with
// hand-computed results observed through the debug outputs.
module tb_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_signal = 1'b0;
  logic [31:0] new_instruction = 32'd0;
  logic        add_into = 1'b0;
  logic        end_signal;
  logic [31:0] debug1, debug2, debug3, debug4, debug5;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  processor dut (
    .clk(clk), .reset(reset), .start_signal(start_signal),
    .new_instruction(new_instruction), .add_into(add_into),
    .end_signal(end_signal), .debug1(debug1), .debug2(debug2),
    .debug3(debug3), .debug4(debug4), .debug5(debug5)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    start_signal = 1'b0;
    add_into     = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_word(input logic target, input logic [31:0] w);
    start_signal    = 1'b0;
    add_into        = target;
    new_instruction = w;
    @(negedge clk);
  endtask

  task automatic run_to_end(input int max_cycles, input string name);
    int k;
    start_signal = 1'b1;
    for (k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (end_signal) break;
    end
    n_cmp++;
    if (end_signal !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: end_signal=%b required 1 within %0d cycles", name, end_signal, max_cycles);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp += 6;
    if (debug1 !== 32'd0) begin n_err++; $display("FAIL rst_debug1: got %h want 0", debug1); end
    if (debug2 !== 32'd0) begin n_err++; $display("FAIL rst_debug2: got %h want 0", debug2); end
    if (debug3 !== 32'd0) begin n_err++; $display("FAIL rst_debug3: got %h want 0", debug3); end
    if (debug4 !== 32'd0) begin n_err++; $display("FAIL rst_debug4: got %h want 0", debug4); end
    if (debug5 !== 32'd0) begin n_err++; $display("FAIL rst_debug5: got %h want 0", debug5); end
    if (end_signal !== 1'b0) begin n_err++; $display("FAIL rst_end: got %b want 0", end_signal); end
    reset = 1'b1;
    load_word(1'b0, 32'h0400_000C);
    n_cmp++;
    if (debug5 !== 32'h0400_000C) begin n_err++; $display("FAIL load_imem0: got %h want 0400000c", debug5); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (debug5 !== 32'd0) begin n_err++; $display("FAIL async_clear_imem: got %h want 0", debug5); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_alu_program();
    do_reset();
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd12, 16'd5));
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd13, 16'hFFFD));
    load_word(1'b0, enc_r(6'b000000, 5'd12, 5'd13, 5'd12, 5'd0));
    load_word(1'b0, HALT);
    run_to_end(20, "alu");
    n_cmp += 3;
    if (debug4 !== 32'd2) begin n_err++; $display("FAIL alu_r12: got %0d want 2", debug4); end
    if (debug1 !== 32'd4) begin n_err++; $display("FAIL alu_retired: got %0d want 4", debug1); end
    if (debug2 !== 32'd3) begin n_err++; $display("FAIL alu_pc: got %0d want 3", debug2); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (end_signal !== 1'b1 || debug1 !== 32'd4) begin
        n_err++;
        $display("FAIL alu_hold[%0d]: end=%b retired=%0d want end=1 retired=4", i, end_signal, debug1);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_r12 [15];
    exp_r12 = '{32'd0, 32'd0, 32'hFFFF_FFF7, 32'd2, 32'hFFFF_FFFB, 32'd1, 32'd0,
                32'd48, 32'hF, 32'h8003, 32'd24, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                32'hFFFF_FFFD, 32'hFFFF_FFFD};
    do_reset();
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd1, 16'hFFFA));
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd2, 16'd3));
    load_word(1'b0, enc_r(6'b000001, 5'd1, 5'd2, 5'd12, 5'd0));
    load_word(1'b0, enc_r(6'b000010, 5'd1, 5'd2, 5'd12, 5'd0));
    load_word(1'b0, enc_r(6'b000011, 5'd1, 5'd2, 5'd12, 5'd0));
    load_word(1'b0, enc_r(6'b000100, 5'd1, 5'd2, 5'd12, 5'd0));
    load_word(1'b0, enc_r(6'b000100, 5'd2, 5'd1, 5'd12, 5'd0));
    load_word(1'b0, enc_r(6'b000101, 5'd0, 5'd2, 5'd12, 5'd4));
    load_word(1'b0, enc_r(6'b000110, 5'd0, 5'd1, 5'd12, 5'd28));
    load_word(1'b0, enc_i(6'b000011, 5'd2, 5'd12, 16'h8000));
    load_word(1'b0, enc_i(6'b000111, 5'd2, 5'd12, 16'd3));
    load_word(1'b0, enc_r(6'b000000, 5'd1, 5'd2, 5'd12, 5'd0));
    load_word(1'b0, enc_r(6'b111111, 5'd1, 5'd2, 5'd12, 5'd0));
    load_word(1'b0, enc_i(6'b001010, 5'd2, 5'd2, 16'd1));
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd12, 16'd99));
    load_word(1'b0, HALT);
    start_signal = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if (debug4 !== exp_r12[k]) begin
        n_err++;
        $display("FAIL ops_step%0d: r12=%h want %h", k, debug4, exp_r12[k]);
      end
    end
    n_cmp += 2;
    if (end_signal !== 1'b1) begin n_err++; $display("FAIL ops_end: got %b want 1", end_signal); end
    if (debug2 !== 32'd15) begin n_err++; $display("FAIL ops_pc: got %0d want 15", debug2); end
  endtask

  task automatic test_load_store();
    do_reset();
    load_word(1'b1, 32'd7);
    load_word(1'b1, 32'd9);
    load_word(1'b0, enc_i(6'b001000, 5'd0, 5'd12, 16'd1));
    load_word(1'b0, enc_i(6'b001001, 5'd0, 5'd12, 16'd0));
    load_word(1'b0, HALT);
    n_cmp++;
    if (debug3 !== 32'd7) begin n_err++; $display("FAIL ls_preload: got %0d want 7", debug3); end
    run_to_end(20, "ls");
    n_cmp += 2;
    if (debug3 !== 32'd9) begin n_err++; $display("FAIL ls_dmem0: got %0d want 9", debug3); end
    if (debug4 !== 32'd9) begin n_err++; $display("FAIL ls_r12: got %0d want 9", debug4); end
  endtask

  task automatic load_loop_program();
    do_reset();
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd12, 16'd0));
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd13, 16'd4));
    load_word(1'b0, enc_i(6'b000001, 5'd12, 5'd12, 16'd1));
    load_word(1'b0, enc_i(6'b001011, 5'd12, 5'd13, 16'hFFFE));
    load_word(1'b0, HALT);
  endtask

  task automatic test_branch_loop();
    load_loop_program();
    run_to_end(40, "loop");
    n_cmp += 3;
    if (debug4 !== 32'd4)  begin n_err++; $display("FAIL loop_r12: got %0d want 4", debug4); end
    if (debug1 !== 32'd11) begin n_err++; $display("FAIL loop_retired: got %0d want 11", debug1); end
    if (debug2 !== 32'd4)  begin n_err++; $display("FAIL loop_pc: got %0d want 4", debug2); end
  endtask

  task automatic test_jump_undef();
    do_reset();
    load_word(1'b0, {6'b100001, 26'd3});
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd12, 16'd1));
    load_word(1'b0, HALT);
    load_word(1'b0, {6'b010101, 26'h155_5555});
    load_word(1'b0, enc_i(6'b000001, 5'd0, 5'd12, 16'd8));
    load_word(1'b0, HALT);
    run_to_end(20, "jump");
    n_cmp += 3;
    if (debug4 !== 32'd8) begin n_err++; $display("FAIL jump_r12: got %0d want 8", debug4); end
    if (debug2 !== 32'd5) begin n_err++; $display("FAIL jump_pc: got %0d want 5", debug2); end
    if (debug1 !== 32'd4) begin n_err++; $display("FAIL jump_retired: got %0d want 4", debug1); end
  endtask

  task automatic test_pause();
    load_loop_program();
    start_signal = 1'b1;
    repeat (5) @(negedge clk);
    // Pause with the load port aimed at spare data words so nothing live is disturbed.
    start_signal    = 1'b0;
    add_into        = 1'b1;
    new_instruction = 32'd0;
    repeat (4) @(negedge clk);
    n_cmp += 3;
    if (debug2 !== 32'd3) begin n_err++; $display("FAIL pause_pc: got %0d want 3", debug2); end
    if (debug1 !== 32'd5) begin n_err++; $display("FAIL pause_retired: got %0d want 5", debug1); end
    if (debug4 !== 32'd2) begin n_err++; $display("FAIL pause_r12: got %0d want 2", debug4); end
    run_to_end(40, "pause");
    n_cmp += 2;
    if (debug4 !== 32'd4)  begin n_err++; $display("FAIL resume_r12: got %0d want 4", debug4); end
    if (debug1 !== 32'd11) begin n_err++; $display("FAIL resume_retired: got %0d want 11", debug1); end
  endtask

  task automatic test_dptr_wrap();
    do_reset();
    for (int k = 0; k < 64; k++) load_word(1'b1, 32'h100 + k);
    n_cmp++;
    if (debug3 !== 32'h100) begin n_err++; $display("FAIL wrap_before: got %h want 00000100", debug3); end
    load_word(1'b1, 32'h140);
    n_cmp++;
    if (debug3 !== 32'h140) begin n_err++; $display("FAIL wrap_after: got %h want 00000140", debug3); end
  endtask

  initial begin
    test_reset();
    test_alu_program();
    test_alu_ops();
    test_load_store();
    test_branch_loop();
    test_jump_undef();
    test_pause();
    test_dptr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
